// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and line-word helper for the direct-mapped instruction cache.
package icache_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam int          ICACHE_LINE_BITS = 512;
    localparam int          ICACHE_BEAT_BITS = 128;
    localparam int          ICACHE_BEATS     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_REFILL = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Select 32-bit word w (0..15) of a 512-bit line.
    function automatic logic [31:0] line_word(input logic [ICACHE_LINE_BITS-1:0] line,
                                              input logic [3:0] w);
        return line[{w, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read, beat-wide
// refill writes and a commit strobe that marks a completed line valid.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = 26 - IDX_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic                        rd_valid,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [ICACHE_LINE_BITS-1:0] rd_line,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [1:0]                  wr_beat,
    input  logic [ICACHE_BEAT_BITS-1:0] wr_data,
    input  logic                        commit,
    input  logic [IDX_W-1:0]            commit_idx,
    input  logic [TAG_W-1:0]            commit_tag
);

    logic [LINES-1:0]            valid_r;
    logic [TAG_W-1:0]            tag_r  [LINES];
    logic [ICACHE_LINE_BITS-1:0] data_r [LINES];

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_line  = data_r[rd_idx];

    // Valid bits: cleared asynchronously, set only when a full line has landed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= '0;
        end else if (commit) begin
            valid_r[commit_idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[wr_idx][{wr_beat, 7'd0} +: ICACHE_BEAT_BITS] <= wr_data;
        end
        if (commit) begin
            tag_r[commit_idx] <= commit_tag;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 4-beat line refill.
// Optional hit/miss counters are enabled with `define ICACHE_STATS_EN.
module icache
    import icache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cpu_req_valid,
    output logic         cpu_req_ready,
    input  logic [31:0]  cpu_req_addr,
    output logic         cpu_resp_valid,
    output logic [31:0]  cpu_resp_data,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [27:0]  mem_req_addr,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 26 - IDX_W;

    state_t       state_r, state_s;
    logic [31:0]  addr_r;
    logic [1:0]   issue_cnt_r;
    logic [2:0]   recv_cnt_r;
    logic         resp_valid_r;
    logic [31:0]  resp_data_r;
    logic         mem_req_valid_r;
    logic [27:0]  mem_req_addr_r;

    logic [IDX_W-1:0]            rd_idx_s;
    logic                        rd_valid_s;
    logic [TAG_W-1:0]            rd_tag_s;
    logic [ICACHE_LINE_BITS-1:0] rd_line_s;
    logic accept_s, hit_s, issue_s, capture_s, commit_s;
    logic unused_s;

    assign unused_s = ^{cpu_req_addr[1:0], addr_r[1:0]};

    // During IDLE the array is probed with the live request; otherwise with the latched miss.
    assign rd_idx_s  = (state_r == ST_IDLE) ? cpu_req_addr[6 +: IDX_W] : addr_r[6 +: IDX_W];
    assign hit_s     = rd_valid_s && (rd_tag_s == cpu_req_addr[31 -: TAG_W]);
    assign accept_s  = cpu_req_valid && (state_r == ST_IDLE);
    assign issue_s   = (state_r == ST_REQ) && mem_req_valid_r && mem_req_ready;
    assign capture_s = ((state_r == ST_REQ) || (state_r == ST_REFILL)) && mem_resp_valid
                       && (recv_cnt_r < 3'd4);
    assign commit_s  = (state_r == ST_REFILL) && (recv_cnt_r == 3'd4);

    assign cpu_req_ready  = (state_r == ST_IDLE);
    assign cpu_resp_valid = resp_valid_r;
    assign cpu_resp_data  = resp_data_r;
    assign mem_req_valid  = mem_req_valid_r;
    assign mem_req_addr   = mem_req_addr_r;

    icache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_idx     (rd_idx_s),
        .rd_valid   (rd_valid_s),
        .rd_tag     (rd_tag_s),
        .rd_line    (rd_line_s),
        .wr_en      (capture_s),
        .wr_idx     (addr_r[6 +: IDX_W]),
        .wr_beat    (recv_cnt_r[1:0]),
        .wr_data    (mem_resp_data),
        .commit     (commit_s),
        .commit_idx (addr_r[6 +: IDX_W]),
        .commit_tag (addr_r[31 -: TAG_W])
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !hit_s) state_s = ST_REQ;
                else                    state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (issue_s && (issue_cnt_r == 2'd3)) state_s = ST_REFILL;
                else                                  state_s = ST_REQ;
            end
            ST_REFILL: begin
                if (commit_s) state_s = ST_RESP;
                else          state_s = ST_REFILL;
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: address latch, beat counters, response and memory-request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r          <= 32'd0;
            issue_cnt_r     <= 2'd0;
            recv_cnt_r      <= 3'd0;
            resp_valid_r    <= 1'b0;
            resp_data_r     <= INSTR_NOP;
            mem_req_valid_r <= 1'b0;
            mem_req_addr_r  <= 28'd0;
        end else begin
            resp_valid_r <= (accept_s && hit_s) || (state_r == ST_RESP);
            if (accept_s) begin
                addr_r <= cpu_req_addr;
            end
            if (accept_s && hit_s) begin
                resp_data_r <= line_word(rd_line_s, cpu_req_addr[5:2]);
            end else if (state_r == ST_RESP) begin
                resp_data_r <= line_word(rd_line_s, addr_r[5:2]);
            end
            if (accept_s && !hit_s) begin
                mem_req_valid_r <= 1'b1;
                mem_req_addr_r  <= {cpu_req_addr[31:6], 2'd0};
            end else if (issue_s) begin
                if (issue_cnt_r == 2'd3) mem_req_valid_r <= 1'b0;
                else                     mem_req_addr_r  <= {addr_r[31:6], issue_cnt_r + 2'd1};
            end
            if (issue_s) begin
                issue_cnt_r <= issue_cnt_r + 2'd1;
            end else if (state_r == ST_RESP) begin
                issue_cnt_r <= 2'd0;
            end
            if (capture_s) begin
                recv_cnt_r <= recv_cnt_r + 3'd1;
            end else if (state_r == ST_RESP) begin
                recv_cnt_r <= 3'd0;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_r, miss_count_r;
    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

    // Saturating hit/miss counters, one step per accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else if (accept_s) begin
            if (hit_s && (hit_count_r != 32'hFFFF_FFFF))
                hit_count_r <= hit_count_r + 32'd1;
            if (!hit_s && (miss_count_r != 32'hFFFF_FFFF))
                miss_count_r <= miss_count_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Scoreboard testbench for icache: directed fetches against a behavioural memory model.
module tb_icache;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic [31:0]  cpu_req_addr;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [27:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    icache #(.LINES(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_data  (cpu_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mem_beats = 0;
    int mem_resps = 0;
    int mem_lat = 2;
    bit bp_mode = 1'b0;

    logic [31:0] sb_q[$];
    logic [27:0] exp_beat_q[$];
    logic [27:0] pend_addr[$];
    int          pend_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] == 30'h12) return 32'h0050_0093;
        return 32'hC0DE_0000 ^ {16'd0, a[17:2]};
    endfunction

    // Memory model: checks request addresses, returns beats in order after mem_lat cycles.
    initial begin
        logic [27:0] ba;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                pend_addr.delete();
                pend_cyc.delete();
                exp_beat_q.delete();
            end else begin
                mem_req_ready = bp_mode ? ~mem_req_ready : 1'b1;
                if (mem_req_valid && mem_req_ready) begin
                    mem_beats++;
                    if (exp_beat_q.size() == 0) begin
                        chk("unexpected_mem_req", {4'd0, mem_req_addr}, 32'hFFFF_FFFF);
                    end else begin
                        chk("mem_req_addr", {4'd0, mem_req_addr}, {4'd0, exp_beat_q.pop_front()});
                    end
                    pend_addr.push_back(mem_req_addr);
                    pend_cyc.push_back(cyc + 1);
                end
                if (pend_cyc.size() > 0 && cyc >= pend_cyc[0] + mem_lat) begin
                    ba = pend_addr.pop_front();
                    void'(pend_cyc.pop_front());
                    for (int w = 0; w < 4; w++)
                        mem_resp_data[w*32 +: 32] = mem_word({ba, w[1:0], 2'b00});
                    mem_resp_valid = 1'b1;
                    mem_resps++;
                end else begin
                    mem_resp_valid = 1'b0;
                end
            end
        end
    end

    // Response monitor: every cpu_resp_valid pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && cpu_resp_valid) begin
                if (sb_q.size() == 0) chk("unexpected_resp", cpu_resp_data, 32'hDEAD_DEAD);
                else                  chk("resp_data", cpu_resp_data, sb_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr = 32'd0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        chk("rst_resp_data", cpu_resp_data, 32'h0000_0013);
        chk("rst_req_ready", {31'd0, cpu_req_ready}, 32'd1);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_req_addr", {4'd0, mem_req_addr}, 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input logic exp_hit,
                         input string nm);
        int b0, bad_ready, t;
        b0 = mem_beats;
        bad_ready = 0;
        @(negedge clk);
        t = 0;
        while (!cpu_req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_ready"}, {31'd0, cpu_req_ready}, 32'd1);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        sb_q.push_back(exp);
        if (!exp_hit)
            for (int i = 0; i < 4; i++) exp_beat_q.push_back({a[31:6], i[1:0]});
        @(negedge clk);
        cpu_req_valid = 1'b0;
        if (exp_hit) chk({nm, "_hit_latency"}, {31'd0, cpu_resp_valid}, 32'd1);
        t = 0;
        while (!cpu_resp_valid && t < 200) begin
            if (cpu_req_ready) bad_ready++;
            @(negedge clk);
            t++;
        end
        chk({nm, "_resp_seen"}, {31'd0, cpu_resp_valid}, 32'd1);
        if (!exp_hit) chk({nm, "_ready_low"}, bad_ready, 32'd0);
        chk({nm, "_beats"}, mem_beats - b0, exp_hit ? 32'd0 : 32'd4);
    endtask

    task automatic b2b(input logic [31:0] base, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ev[4];
        int b0;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        b0 = mem_beats;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cpu_req_valid = 1'b1;
            cpu_req_addr  = base + 32'(4 * i);
            sb_q.push_back(ev[i]);
            @(negedge clk);
            chk("b2b_pulse", {31'd0, cpu_resp_valid}, 32'd1);
        end
        cpu_req_valid = 1'b0;
        chk("b2b_no_mem", mem_beats - b0, 32'd0);
    endtask

    initial begin
        int b0, t;
        reset_n = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr = 32'd0;
        do_reset();

        // Cold miss then repeat hit.
        fetch(32'h0000_0048, 32'h0050_0093, 1'b0, "cold_miss");
        fetch(32'h0000_0048, 32'h0050_0093, 1'b1, "rehit");
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, 32'd1);
        chk("miss_count", miss_count, 32'd1);
`endif

        b2b(32'h0000_0040, 32'hC0DE_0010, 32'hC0DE_0011, 32'h0050_0093, 32'hC0DE_0013);

        // Index conflict: 0x0 and 0x400 share line 0.
        fetch(32'h0000_0000, 32'hC0DE_0000, 1'b0, "conf_a");
        fetch(32'h0000_0400, 32'hC0DE_0100, 1'b0, "conf_b");
        fetch(32'h0000_0000, 32'hC0DE_0000, 1'b0, "conf_a2");

        // Backpressure with responses overlapping issues.
        bp_mode = 1'b1;
        mem_lat = 0;
        fetch(32'h0000_1000, 32'hC0DE_0400, 1'b0, "bp_miss");
        bp_mode = 1'b0;
        mem_lat = 2;
        fetch(32'h0000_103C, 32'hC0DE_040F, 1'b1, "bp_line_end");
        fetch(32'h0000_1024, 32'hC0DE_0409, 1'b1, "bp_line_mid");

        // Reset asserted after two beats have returned.
        mem_lat = 3;
        b0 = mem_resps;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = 32'h0000_2008;
        for (int i = 0; i < 4; i++) exp_beat_q.push_back({26'h80, i[1:0]});
        @(negedge clk);
        cpu_req_valid = 1'b0;
        t = 0;
        while ((mem_resps - b0) < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_reset_two_beats", mem_resps - b0, 32'd2);
        @(negedge clk);
        do_reset();
        mem_lat = 2;
        fetch(32'h0000_2008, 32'hC0DE_0802, 1'b0, "post_reset_miss");
        fetch(32'h0000_2000, 32'hC0DE_0800, 1'b1, "post_reset_hit");

        repeat (5) @(negedge clk);
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
